// File: rtl/unsigned32_mult.sv
// rtl/unsigned32_mult.sv - sequential unsigned radix-2 shift-add multiplier
module unsigned32_mult #(
    parameter int WIDTH = 32,
    parameter int CW    = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic [2*WIDTH-1:0] P,
    output logic               ok,
    output logic               done,
    output logic               ovf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic [CW-1:0]    r_cnt;
    logic             r_done;
    logic [WIDTH:0]   w_sum;

    // The carry out of the adder is kept and shifted into the top of acc_hi.
    assign w_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_mcand  <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_mcand  <= A;
                        r_acc_lo <= B;
                        r_acc_hi <= '0;
                        r_cnt    <= CW'(WIDTH - 1);
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc_hi <= w_sum[WIDTH:1];
                    r_acc_lo <= {w_sum[0], r_acc_lo[WIDTH-1:1]};
                    r_cnt    <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign P    = {r_acc_hi, r_acc_lo};
    assign ok   = (r_state != S_RUN);
    assign done = r_done;
    assign ovf  = |r_acc_hi;

endmodule

// File: tb/tb_unsigned32_mult.sv
// tb/tb_unsigned32_mult.sv - scoreboard bench for unsigned32_mult
module tb_unsigned32_mult;

    localparam int WIDTH = 32;

    logic               clk;
    logic               reset;
    logic               start;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [2*WIDTH-1:0] p;
    logic               ok;
    logic               done;
    logic               ovf;

    unsigned32_mult #(.WIDTH(WIDTH), .CW(6)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .A     (a),
        .B     (b),
        .P     (p),
        .ok    (ok),
        .done  (done),
        .ovf   (ovf)
    );

    typedef struct {
        logic [63:0] prod;
        int          load_cyc;
    } exp_t;

    exp_t sb[$];
    int   done_cycs[$];
    int   cyc;
    int   n_checks;
    int   n_errors;
    logic prev_done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Compare each completed operation against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset) begin
            if (prev_done) chk("done_width", {63'd0, done}, 64'd0);
            if (done) begin
                done_cycs.push_back(cyc);
                if (sb.size() == 0) begin
                    chk("spurious_done", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("P", p, e.prod);
                    chk("ovf", {63'd0, ovf}, {63'd0, |e.prod[63:32]});
                    chk("ok_at_done", {63'd0, ok}, 64'd1);
                    if (e.load_cyc >= 0) chk("latency", 64'(cyc - e.load_cyc), 64'(WIDTH));
                end
            end
            prev_done <= done;
        end else begin
            prev_done <= 1'b0;
        end
    end

    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y);
        longint unsigned r;
        r = longint'(x) * longint'(y);
        return r;
    endfunction

    task automatic run_op(input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        @(negedge clk); #1;
        a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom; b = $urandom;
        e.prod = model(x, y);
        e.load_cyc = cyc;
        sb.push_back(e);
        chk("ok_low_after_load", {63'd0, ok}, 64'd0);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        chk(tag, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        exp_t e;
        n_checks = 0; n_errors = 0; cyc = 0;
        prev_done = 1'b0;
        reset = 1'b0; start = 1'b0; a = '0; b = '0;
        #1;
        chk("rst_P", p, 64'd0);
        chk("rst_ok", {63'd0, ok}, 64'd1);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_ovf", {63'd0, ovf}, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        run_op(32'd3, 32'd5);
        wait_drain("drain_3x5");
        repeat (3) @(negedge clk);
        chk("hold_P", p, 64'h0000_0000_0000_000F);
        chk("hold_ok", {63'd0, ok}, 64'd1);
        chk("hold_done", {63'd0, done}, 64'd0);

        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_drain("drain_max");
        chk("max_P", p, 64'hFFFF_FFFE_0000_0001);
        run_op(32'h0001_0000, 32'h0001_0000);
        wait_drain("drain_pow");
        chk("pow_ovf", {63'd0, ovf}, 64'd1);
        run_op(32'd0, 32'h1234_5678);
        wait_drain("drain_zero");
        chk("zero_P", p, 64'd0);

        for (int i = 0; i < 4; i++) begin
            run_op($urandom, $urandom);
            wait_drain("drain_rand");
        end

        // Start re-pulsed mid-run with different operands must be ignored.
        run_op(32'd7, 32'd9);
        repeat (9) @(negedge clk);
        #1; a = 32'd2; b = 32'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("ok_low_ignored_start", {63'd0, ok}, 64'd0);
        wait_drain("drain_ignore");
        chk("ignore_P", p, 64'd63);

        // Reset asserted mid-run aborts immediately.
        run_op(32'd100, 32'd200);
        repeat (14) @(negedge clk);
        #1; reset = 1'b0;
        #1;
        sb.delete();
        chk("abort_P", p, 64'd0);
        chk("abort_ok", {63'd0, ok}, 64'd1);
        chk("abort_done", {63'd0, done}, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        run_op(32'd6, 32'd7);
        wait_drain("drain_after_rst");
        chk("after_rst_P", p, 64'd42);

        // Start held high: back-to-back operations, one done pulse each.
        done_cycs.delete();
        @(negedge clk); #1;
        a = 32'd10; b = 32'd10; start = 1'b1;
        e.prod = 64'd100; e.load_cyc = -1;
        repeat (3) sb.push_back(e);
        wait_drain("drain_held");
        start = 1'b0;
        if (done_cycs.size() >= 3) begin
            chk("held_spacing0", 64'(done_cycs[1] - done_cycs[0]), 64'(WIDTH + 1));
            chk("held_spacing1", 64'(done_cycs[2] - done_cycs[1]), 64'(WIDTH + 1));
        end else begin
            chk("held_count", 64'(done_cycs.size()), 64'd3);
        end
        repeat (3) @(negedge clk);
        chk("held_stop_ok", {63'd0, ok}, 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
